control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle fetch/decode/execute sequencer for the 8-bit uProcessor. It reads instructions from program memory and owns the PC, IR, accumulator, carry flag and zero flag. It drives the ALU's operation code, carry-in and accumulator operand, then commits the ALU result and carry-out back into architectural state. It sits between program memory, data memory and the ALU, and is the producer of the `ALU_*` codes defined in defines.sv.

## Interface
Parameters: none (8-bit data, 8-bit PC, 16-byte data space fixed).
- Clk  in  1  single clock; all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- PAddr  out  8  program memory address (synchronous ROM, 1-cycle read latency)
- PData  in  8  program memory read data, valid the cycle after PAddr
- DAddr  out  4  data memory address (synchronous RAM, 1-cycle read latency)
- DRdData  in  8  data memory read data, also wired to ALU MemIn externally
- DWrData  out  8  data memory write data (= Accu)
- DWe  out  1  data memory write enable
- ALUCode  out  3  ALU operation (`ALU_*` from defines.sv)
- ALUCi  out  1  ALU carry-in
- ALUAccu  out  8  accumulator value to ALU Accu input
- ALUCo  in  1  ALU carry-out
- ALUOut  in  8  ALU result
- CarryFlag  out  1  architectural C
- ZeroFlag  out  1  architectural Z
- Halted  out  1  high while in HALT

## Operation
- Instruction word: IR[7:4] = opcode, IR[3:0] = data address. Jumps are two words; the second word is the 8-bit target.
- Opcodes and their ALUCode / ALUCi:
  - 0 NOP
  - 1 ADD: `ALU_ADD`, Ci=0
  - 2 ADC: `ALU_ADD`, Ci=C
  - 3 SUB: `ALU_SUB`, Ci=0
  - 4 SBC: `ALU_SUB`, Ci=C
  - 5 AND: `ALU_AND`
  - 6 OR: `ALU_OR`
  - 7 XOR: `ALU_XOR`
  - 8 NOT: `ALU_NOT`
  - 9 LD: `ALU_LD`
  - A ST
  - B JMP
  - C JC (jump if C=1)
  - D JZ (jump if Z=1)
  - E CLC
  - F HALT
- ALUCode and ALUCi are a pure function of IR and C in every state. Non-ALU opcodes drive `ALU_LD` with Ci=0. ALUCi=0 except for ADC and SBC.
- State machine states: FETCH, DECODE, MEMRD, EXEC, STORE, JFETCH, JUMP, HALT.
  - FETCH: PAddr=PC. Next state DECODE.
  - DECODE: IR<=PData; PC<=PC+1. Next state depends on PData[7:4]:
    - ADD..XOR and LD → MEMRD
    - NOT → EXEC
    - ST → STORE
    - JMP/JC/JZ → JFETCH
    - NOP → FETCH
    - CLC → FETCH, with C<=0
    - HALT → HALT
  - MEMRD: DAddr=IR[3:0]. Next state EXEC.
  - EXEC: Accu<=ALUOut; Z<=(ALUOut==0). C<=ALUCo only for ADD/ADC/SUB/SBC; C is unchanged for AND/OR/XOR/NOT/LD. Next state FETCH.
  - STORE: DAddr=IR[3:0], DWrData=Accu, DWe=1. Next state FETCH.
  - JFETCH: PAddr=PC (the operand word). Next state JUMP.
  - JUMP: if taken, PC<=PData; else PC<=PC+1. Next state FETCH. JMP is always taken.
  - HALT: no state changes. Halted=1. Exits only via Rst.
- DAddr = IR[3:0] in all states. DWe = (state==STORE) & ~Rst.
- PAddr = PC in all states.
- ALUAccu = Accu register.
- SUB/SBC carry is borrow, i.e. bit 8 of the 9-bit difference as produced by the ALU.
- PC arithmetic is modulo 256: 0xFF+1 = 0x00, including when the operand word is fetched across the wrap.

## Timing
- Reset values: PC=0x00, IR=0x00, Accu=0x00, C=0, Z=0, state=FETCH.
  - Therefore DWe=0, Halted=0, PAddr=0x00, DAddr=0x0, ALUCode=`ALU_LD`, ALUCi=0.
- Cycles per instruction:
  - NOP / CLC: 2
  - NOT / ST: 3
  - ALU memory ops: 4
  - JMP / JC / JZ: 4, taken or not
  - HALT: 2 cycles to enter HALT
- Accu, C and Z are visible the cycle after EXEC. A back-to-back dependent instruction sees the new Accu, because EXEC always precedes the next FETCH.
- Rst has priority over every state, including a pending STORE: no write occurs in the cycle Rst is high. Rst during HALT returns to FETCH at PC=0.
- JC and JZ sample C and Z in the JUMP cycle. These are the flags committed by the previous instruction.

## Test plan
- Reset and ADD:
  - Stimulus: DMEM[3]=0x05; program LD 3 (0x93), ADD 3 (0x13), ST 4 (0xA4), HALT.
  - Required: Accu=0x0A, DMEM[4]=0x0A, C=0, Z=0, Halted=1, with HALT entered 13 cycles after reset release.
- Carry chain:
  - Stimulus: Accu=0xFF via LD, then ADD of 0x01.
  - Required: Accu=0x00, C=1, Z=1. A following ADC of 0x00 then gives Accu=0x01, C=0.
- Borrow:
  - Stimulus: LD 0x00, then SUB of 0x01.
  - Required: Accu=0xFF, C=1. A following SBC of 0x00 gives Accu=0xFE, C=0.
- Conditional jumps:
  - Stimulus: JZ 0x40 with Z=0.
  - Required: PC=0x02 after 4 cycles.
  - Stimulus: set Z via XOR with self, then JZ 0x40.
  - Required: PC=0x40, and C is unchanged by the XOR.
- Wrap-around:
  - Stimulus: JMP 0x00 placed at 0xFF, so its operand is fetched from address 0x00.
  - Required: PC loads PData read at address 0x00.
  - Stimulus: CLC at 0xFF.
  - Required: PC wraps to 0x00.
- Reset mid-STORE:
  - Stimulus: assert Rst during the STORE cycle.
  - Required: DWe=0 in that cycle, DMEM unchanged, state=FETCH, PC=0 next cycle.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for the 8-bit uProcessor
module control_unit (
  input  logic       Clk,
  input  logic       Rst,
  output logic [7:0] PAddr,
  input  logic [7:0] PData,
  output logic [3:0] DAddr,
  input  logic [7:0] DRdData,
  output logic [7:0] DWrData,
  output logic       DWe,
  output logic [2:0] ALUCode,
  output logic       ALUCi,
  output logic [7:0] ALUAccu,
  input  logic       ALUCo,
  input  logic [7:0] ALUOut,
  output logic       CarryFlag,
  output logic       ZeroFlag,
  output logic       Halted
);
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_LD  = 3'd6;
  typedef enum logic [2:0] {FETCH, DECODE, MEMRD, EXEC, STORE, JFETCH, JUMP, HALT} state_t;
  state_t     state;
  logic [7:0] pc, ir, accu;
  logic       c, z;
  logic [3:0] op;
  logic       taken;
  logic       unused_mem;
  assign op         = ir[7:4];
  assign taken      = (op == 4'hB) | ((op == 4'hC) & c) | ((op == 4'hD) & z);
  assign PAddr      = pc;
  assign DAddr      = ir[3:0];
  assign DWrData    = accu;
  assign ALUAccu    = accu;
  assign CarryFlag  = c;
  assign ZeroFlag   = z;
  assign Halted     = (state == HALT);
  assign DWe        = (state == STORE) & ~Rst;
  // memory read data feeds the ALU directly, the sequencer never inspects it
  assign unused_mem = ^DRdData;
  // ALU operation select depends only on the latched opcode and the carry flag
  always_comb begin
    ALUCode = (op == 4'h1 || op == 4'h2) ? ALU_ADD :
              (op == 4'h3 || op == 4'h4) ? ALU_SUB :
              (op == 4'h5) ? ALU_AND :
              (op == 4'h6) ? ALU_OR  :
              (op == 4'h7) ? ALU_XOR :
              (op == 4'h8) ? ALU_NOT : ALU_LD;
    ALUCi   = (op == 4'h2 || op == 4'h4) & c;
  end
  // sequencer: state walk plus PC/IR/accumulator/flag commits
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= FETCH;
      pc    <= 8'h00;
      ir    <= 8'h00;
      accu  <= 8'h00;
      c     <= 1'b0;
      z     <= 1'b0;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          ir <= PData;
          pc <= pc + 8'd1;
          case (PData[7:4])
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9: state <= MEMRD;
            4'h8:             state <= EXEC;
            4'hA:             state <= STORE;
            4'hB, 4'hC, 4'hD: state <= JFETCH;
            4'hE: begin
              c     <= 1'b0;
              state <= FETCH;
            end
            4'hF:             state <= HALT;
            default:          state <= FETCH;
          endcase
        end
        MEMRD:  state <= EXEC;
        EXEC: begin
          accu  <= ALUOut;
          z     <= (ALUOut == 8'h00);
          if (op >= 4'h1 && op <= 4'h4) c <= ALUCo;
          state <= FETCH;
        end
        STORE:  state <= FETCH;
        JFETCH: state <= JUMP;
        JUMP: begin
          pc    <= taken ? PData : pc + 8'd1;
          state <= FETCH;
        end
        HALT:   state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: instruction-level reference model plus directed programs for control_unit
module tb_control_unit;
  localparam logic [2:0] A_ADD = 3'd0;
  localparam logic [2:0] A_SUB = 3'd1;
  localparam logic [2:0] A_AND = 3'd2;
  localparam logic [2:0] A_OR  = 3'd3;
  localparam logic [2:0] A_XOR = 3'd4;
  localparam logic [2:0] A_NOT = 3'd5;
  localparam logic [2:0] A_LD  = 3'd6;
  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] PAddr, PData, DWrData, ALUAccu, ALUOut, DRdData;
  logic [3:0] DAddr;
  logic       DWe, ALUCi, ALUCo, CarryFlag, ZeroFlag, Halted;
  logic [2:0] ALUCode;
  logic [7:0] rom [256];
  logic [7:0] ram [16];
  logic [7:0] img [16];
  logic       load = 1'b0;
  int         checks = 0;
  int         errors = 0;
  control_unit dut (
    .Clk(Clk), .Rst(Rst), .PAddr(PAddr), .PData(PData), .DAddr(DAddr),
    .DRdData(DRdData), .DWrData(DWrData), .DWe(DWe), .ALUCode(ALUCode),
    .ALUCi(ALUCi), .ALUAccu(ALUAccu), .ALUCo(ALUCo), .ALUOut(ALUOut),
    .CarryFlag(CarryFlag), .ZeroFlag(ZeroFlag), .Halted(Halted)
  );
  always #5 Clk = ~Clk;
  function automatic logic [8:0] alu(input logic [2:0] code, input logic ci, input logic [7:0] a, input logic [7:0] m);
    case (code)
      A_ADD:   return {1'b0, a} + {1'b0, m} + {8'b0, ci};
      A_SUB:   return {1'b0, a} - {1'b0, m} - {8'b0, ci};
      A_AND:   return {1'b0, a & m};
      A_OR:    return {1'b0, a | m};
      A_XOR:   return {1'b0, a ^ m};
      A_NOT:   return {1'b0, ~a};
      default: return {1'b0, m};
    endcase
  endfunction
  function automatic logic [2:0] exp_code(input logic [3:0] o);
    case (o)
      4'h1, 4'h2: return A_ADD;
      4'h3, 4'h4: return A_SUB;
      4'h5:       return A_AND;
      4'h6:       return A_OR;
      4'h7:       return A_XOR;
      4'h8:       return A_NOT;
      default:    return A_LD;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always_comb {ALUCo, ALUOut} = alu(ALUCode, ALUCi, ALUAccu, DRdData);
  always @(posedge Clk) PData <= rom[PAddr];
  always @(posedge Clk) begin
    if (load) ram <= img;
    else begin
      if (DWe) ram[DAddr] <= DWrData;
      DRdData <= ram[DAddr];
    end
  end
  logic [7:0] m_pc, m_acc, n_pc, n_acc, ins, mv, p1;
  logic       m_c, m_z, m_halt, n_c, n_z, n_halt, tk;
  logic [7:0] m_dmem [16];
  logic [8:0] s;
  logic [3:0] op;
  logic       was_rst = 1'b1;
  int         cyc = 0;
  int         len = 2;
  task automatic plan();
    ins = rom[m_pc];
    op = ins[7:4];
    mv = m_dmem[ins[3:0]];
    n_pc = m_pc + 8'd1;
    n_acc = m_acc;
    n_c = m_c;
    n_z = m_z;
    n_halt = 1'b0;
    len = 2;
    if (op >= 4'h1 && op <= 4'h9) begin
      len = (op == 4'h8) ? 3 : 4;
      case (op)
        4'h1: s = {1'b0, m_acc} + {1'b0, mv};
        4'h2: s = {1'b0, m_acc} + {1'b0, mv} + {8'b0, m_c};
        4'h3: s = {1'b0, m_acc} - {1'b0, mv};
        4'h4: s = {1'b0, m_acc} - {1'b0, mv} - {8'b0, m_c};
        4'h5: s = {m_c, m_acc & mv};
        4'h6: s = {m_c, m_acc | mv};
        4'h7: s = {m_c, m_acc ^ mv};
        4'h8: s = {m_c, ~m_acc};
        default: s = {m_c, mv};
      endcase
      {n_c, n_acc} = s;
      n_z = (n_acc == 8'h00);
    end else if (op == 4'hA) len = 3;
    else if (op >= 4'hB && op <= 4'hD) begin
      len = 4;
      tk = (op == 4'hB) || (op == 4'hC && m_c) || (op == 4'hD && m_z);
      p1 = m_pc + 8'd1;
      n_pc = tk ? rom[p1] : m_pc + 8'd2;
    end else if (op == 4'hE) n_c = 1'b0;
    else if (op == 4'hF) n_halt = 1'b1;
  endtask
  // reference model advanced once per cycle, compared mid-cycle
  always @(negedge Clk) begin
    if (load) m_dmem = img;
    if (was_rst) begin
      m_pc = 8'h00; m_acc = 8'h00; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0; cyc = 0; op = 4'h0;
    end
    if (cyc == 0 || m_halt) begin
      chk("pc", PAddr, m_pc);
      chk("accu", ALUAccu, m_acc);
      chk("carry", CarryFlag, m_c);
      chk("zero", ZeroFlag, m_z);
    end
    chk("halted", Halted, m_halt);
    if (cyc == 0 && !m_halt) plan();
    if (m_halt) chk("dwe_halt", DWe, 0);
    else begin
      chk("dwe", DWe, (!Rst && op == 4'hA && cyc == 2));
      if (cyc >= 2) begin
        chk("alucode", ALUCode, exp_code(op));
        chk("aluci", ALUCi, (op == 4'h2 || op == 4'h4) && m_c);
        chk("daddr", DAddr, ins[3:0]);
      end
      if (op == 4'hA && cyc == 2) chk("dwrdata", DWrData, m_acc);
    end
    was_rst = Rst;
    if (!Rst && !m_halt) begin
      cyc++;
      if (cyc == len) begin
        if (op == 4'hA) m_dmem[ins[3:0]] = m_acc;
        m_pc = n_pc; m_acc = n_acc; m_c = n_c; m_z = n_z; m_halt = n_halt;
        cyc = 0;
      end
    end
  end
  task automatic prep();
    @(posedge Clk); #1;
    Rst = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    load = 1'b1;
  endtask
  task automatic prog(input logic [127:0] w, input int n);
    for (int i = 0; i < n; i++) rom[i] = w[8*(n-1-i) +: 8];
  endtask
  task automatic go();
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    load = 1'b0;
    Rst = 1'b0;
  endtask
  task automatic run(output int n);
    n = 0;
    while (!Halted && n < 300) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("halt_reached", Halted, 1);
  endtask
  initial begin
    int n;
    prep(); img[3] = 8'h05; prog(128'h9313A4F0, 4); go();
    chk("reset_pc", PAddr, 8'h00);
    chk("reset_dwe", DWe, 0);
    chk("reset_code", ALUCode, A_LD);
    run(n);
    chk("t1_cycles", n, 13);
    chk("t1_accu", ALUAccu, 8'h0A);
    chk("t1_dmem4", ram[4], 8'h0A);
    chk("t1_c", CarryFlag, 0);
    chk("t1_z", ZeroFlag, 0);
    prep(); img[0] = 8'hFF; img[1] = 8'h01; prog(128'h9011F0, 3); go(); run(n);
    chk("t2a_accu", ALUAccu, 8'h00);
    chk("t2a_c", CarryFlag, 1);
    chk("t2a_z", ZeroFlag, 1);
    prep(); img[0] = 8'hFF; img[1] = 8'h01; prog(128'h901122F0, 4); go(); run(n);
    chk("t2b_accu", ALUAccu, 8'h01);
    chk("t2b_c", CarryFlag, 0);
    chk("t2b_cycles", n, 14);
    prep(); img[1] = 8'h01; prog(128'h9031F0, 3); go(); run(n);
    chk("t3a_accu", ALUAccu, 8'hFF);
    chk("t3a_c", CarryFlag, 1);
    prep(); img[1] = 8'h01; prog(128'h903142F0, 4); go(); run(n);
    chk("t3b_accu", ALUAccu, 8'hFE);
    chk("t3b_c", CarryFlag, 0);
    prep(); prog(128'hD040F0, 3); go();
    repeat (4) @(posedge Clk);
    #1;
    chk("t4a_pc", PAddr, 8'h02);
    prep(); img[0] = 8'hFF; img[1] = 8'h01; img[2] = 8'h37; prog(128'h90119272D040, 6); go(); run(n);
    chk("t4b_pc", PAddr, 8'h41);
    chk("t4b_c", CarryFlag, 1);
    chk("t4b_z", ZeroFlag, 1);
    chk("t4b_cycles", n, 22);
    prep(); prog(128'hB0FF, 2); rom[8'hFF] = 8'hB0; go(); run(n);
    chk("t5a_pc", PAddr, 8'hB1);
    chk("t5a_cycles", n, 10);
    prep(); img[0] = 8'hFF; img[1] = 8'h01; prog(128'h9011B0FF, 4); rom[8'hFF] = 8'hE0; go();
    repeat (14) @(posedge Clk);
    #1;
    chk("t5b_pc", PAddr, 8'h00);
    chk("t5b_c", CarryFlag, 0);
    chk("t5b_z", ZeroFlag, 1);
    prep(); img[0] = 8'hF0; img[1] = 8'h3C; img[2] = 8'h0F; prog(128'h90516280A5F0, 6); go(); run(n);
    chk("t7_accu", ALUAccu, 8'hC0);
    chk("t7_dmem5", ram[5], 8'hC0);
    prep(); img[0] = 8'h5A; img[7] = 8'h11; prog(128'h90A7F0, 3); go();
    repeat (6) @(posedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    chk("t6_dwe", DWe, 0);
    @(posedge Clk); #1;
    chk("t6_pc", PAddr, 8'h00);
    chk("t6_dmem7", ram[7], 8'h11);
    chk("t6_halted", Halted, 0);
    Rst = 1'b0;
    run(n);
    chk("t6_cycles", n, 9);
    chk("t6_dmem7_after", ram[7], 8'h5A);
    @(posedge Clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
